serial_parity_rx: RTL and testbench

Bit-serial frame receiver with parity check, one bit per clock, no oversampling. It accepts a start bit, DATA_WIDTH data bits LSB-first, a parity bit and a stop bit, then presents the parallel word with parity and framing status. It is the receive end of the library's parity-protected serial link. Parity checking uses the XOR/XNOR gate primitives; the block adds sequencing, shifting and status registers.

---
 rtl/serial_parity_rx.sv | 119 +++++++++++
 tb/tb_serial_parity_rx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_rx.sv
// serial_parity_rx: bit-serial frame receiver, one bit per clock.
// Frame = start(0), DATA_WIDTH data bits LSB-first, parity bit, stop(1).
// The completed word is presented with parity and framing status; a line
// held low after a bad stop is parked in BREAK so it cannot decode as
// repeated all-zero frames.
module serial_parity_rx #(
    parameter int DATA_WIDTH = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inSerial,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outValid,
    output logic                  outParityErr,
    output logic                  outFrameErr,
    output logic                  outBusy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
    } state_t;

    state_t                state_r;
    logic [CW-1:0]         count_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  run_par_r;
    logic                  par_bit_r;

    logic [DATA_WIDTH:0]   shift_ext_s;
    logic [DATA_WIDTH-1:0] shift_next_s;

    // Parity error: data parity XOR received parity bit XOR the mode bit.
    function automatic logic parity_err(input logic data_par, input logic rx_par);
        return data_par ^ rx_par ^ ODD_PARITY;
    endfunction

    // Shift the incoming bit in at the top so the first data bit ends at bit 0.
    always_comb begin
        shift_ext_s  = {inSerial, shift_r};
        shift_next_s = shift_ext_s[DATA_WIDTH:1];
    end

    // Frame sequencer with registered data and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            count_r      <= '0;
            shift_r      <= '0;
            run_par_r    <= 1'b0;
            par_bit_r    <= 1'b0;
            outData      <= '0;
            outValid     <= 1'b0;
            outParityErr <= 1'b0;
            outFrameErr  <= 1'b0;
            outBusy      <= 1'b0;
        end else begin
            outValid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (inSerial == 1'b0) begin
                        state_r   <= ST_DATA;
                        count_r   <= '0;
                        run_par_r <= 1'b0;
                        outBusy   <= 1'b1;
                    end else begin
                        outBusy <= 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_r   <= shift_next_s;
                    run_par_r <= run_par_r ^ inSerial;
                    if (count_r == LAST_BIT) begin
                        state_r <= ST_PARITY;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                ST_PARITY: begin
                    par_bit_r <= inSerial;
                    state_r   <= ST_STOP;
                end
                ST_STOP: begin
                    outData      <= shift_r;
                    outValid     <= 1'b1;
                    outParityErr <= parity_err(run_par_r, par_bit_r);
                    outFrameErr  <= ~inSerial;
                    if (inSerial == 1'b1) begin
                        state_r <= ST_IDLE;
                        outBusy <= 1'b0;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    // The high sample that ends BREAK is never a start bit.
                    if (inSerial == 1'b1) begin
                        state_r <= ST_IDLE;
                        outBusy <= 1'b0;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    outBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Scoreboard bench for serial_parity_rx: an even-parity and an odd-parity
// instance share one serial line; frames push expected results, a negedge
// monitor pops and compares on every outValid.
module tb_serial_parity_rx;

    logic       clk;
    logic       rst;
    logic       inSerial;
    logic [7:0] e_data, o_data;
    logic       e_valid, o_valid, e_perr, o_perr, e_ferr, o_ferr, e_busy, o_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    exp_t q_even[$];
    exp_t q_odd[$];
    logic prev_e_valid = 1'b0;
    logic prev_o_valid = 1'b0;

    serial_parity_rx #(.DATA_WIDTH(8), .ODD_PARITY(1'b0)) dut_even (
        .clk(clk), .rst(rst), .inSerial(inSerial),
        .outData(e_data), .outValid(e_valid), .outParityErr(e_perr),
        .outFrameErr(e_ferr), .outBusy(e_busy)
    );

    serial_parity_rx #(.DATA_WIDTH(8), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .inSerial(inSerial),
        .outData(o_data), .outValid(o_valid), .outParityErr(o_perr),
        .outFrameErr(o_ferr), .outBusy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Pop one expected entry for the given instance and compare it.
    task automatic check_frame(input bit odd, input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        total++;
        if ((odd ? q_odd.size() : q_even.size()) == 0) begin
            bad++;
            $display("FAIL unexpected_valid %s actual=1 required=0 (cycle %0d)",
                     odd ? "odd" : "even", cyc);
        end else begin
            total--;
            e = odd ? q_odd.pop_front() : q_even.pop_front();
            chk(odd ? "odd_data" : "even_data", 32'(d), 32'(e.data));
            chk(odd ? "odd_perr" : "even_perr", 32'(pe), 32'(e.perr));
            chk(odd ? "odd_ferr" : "even_ferr", 32'(fe), 32'(e.ferr));
            chk(odd ? "odd_valid_cycle" : "even_valid_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Monitor: compare whenever either instance presents a completed frame.
    always @(negedge clk) begin
        if (e_valid === 1'b1) begin
            chk("even_valid_single_cycle", 32'(prev_e_valid), 32'd0);
            check_frame(1'b0, e_data, e_perr, e_ferr);
        end
        if (o_valid === 1'b1) begin
            chk("odd_valid_single_cycle", 32'(prev_o_valid), 32'd0);
            check_frame(1'b1, o_data, o_perr, o_ferr);
        end
        prev_e_valid = e_valid;
        prev_o_valid = o_valid;
    end

    task automatic send_bit(input logic b);
        inSerial = b;
        @(posedge clk);
        #1;
    endtask

    // Issue a frame and push hand-computed expectations for both instances.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input logic pe_even, input logic pe_odd);
        exp_t e;
        e.data = d;
        e.ferr = ~stop;
        e.cyc  = cyc + 11;
        e.perr = pe_even;
        q_even.push_back(e);
        e.perr = pe_odd;
        q_odd.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
    endtask

    initial begin
        rst      = 1'b1;
        inSerial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", 32'(e_data), 32'h0);
        chk("reset_valid", 32'(e_valid), 32'h0);
        chk("reset_perr", 32'(e_perr), 32'h0);
        chk("reset_ferr", 32'(e_ferr), 32'h0);
        chk("reset_busy", 32'(e_busy), 32'h0);
        rst = 1'b0;
        repeat (2) send_bit(1'b1);

        // Good frame 0xA5, parity 0: even ok, odd error.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("busy_after_good_stop", 32'(e_busy), 32'h0);
        send_bit(1'b1);

        // Parity error 0x01/p0, then good 0x3C/p0 clears it.
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        send_bit(1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1);

        // Framing error 0x0F/p0 stop 0, line low 6 cycles, then high.
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("busy_after_bad_stop", 32'(e_busy), 32'h1);
        for (int i = 0; i < 6; i++) begin
            send_bit(1'b0);
            chk("busy_in_break", 32'(e_busy), 32'h1);
        end
        send_bit(1'b1);
        chk("busy_after_break_exit", 32'(e_busy), 32'h0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);

        // Back-to-back 0x00/p0 then 0xFF/p0, no idle gap.
        send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1);

        // Reset after 4 data bits of 0xC3 (1,1,0,0).
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("busy_mid_frame", 32'(e_busy), 32'h1);
        rst      = 1'b1;
        inSerial = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_data", 32'(e_data), 32'h0);
        chk("midreset_valid", 32'(e_valid), 32'h0);
        chk("midreset_perr", 32'(o_perr), 32'h0);
        chk("midreset_ferr", 32'(e_ferr), 32'h0);
        chk("midreset_busy", 32'(e_busy), 32'h0);
        repeat (20) send_bit(1'b1);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1);

        // Odd-parity cases: 0xA5/p1 odd ok, 0xA5/p0 odd error.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);

        // Drain with a bounded wait.
        for (int i = 0; i < 40; i++) begin
            if (q_even.size() != 0 || q_odd.size() != 0) send_bit(1'b1);
        end
        chk("even_queue_drained", 32'(q_even.size()), 32'd0);
        chk("odd_queue_drained", 32'(q_odd.size()), 32'd0);
        chk("final_ferr_hold", 32'(e_ferr), 32'h0);
        chk("final_odd_perr_hold", 32'(o_perr), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
